cic_comp_fir: RTL
=================

Name: cic_comp_fir

Overview:
- Decimate-by-2 CIC droop-compensation FIR.
- Sits directly downstream of the 3-stage R=32 CIC decimator and consumes its 16-bit output, one sample per CIC output period.
- 16-tap symmetric FIR using one time-shared pre-add/multiply/accumulate datapath.
- Emits one 16-bit compensated sample per two input samples, with a single-cycle valid strobe.

Parameters:
- NTAP, 16: tap count; even, symmetric; NTAP/2 MAC cycles per output.
- DW, 16: input sample width, signed two's complement.
- CW, 12: coefficient width, signed Q1.11 (CW-1 fractional bits).
- OW, 16: output sample width, signed.
- AW, 32: accumulator width; equals DW+1+CW+log2(NTAP/2).

Ports:
- cmp_clk  in  1  single clock, same clock as the CIC decimator.
- cmp_rstn  in  1  asynchronous active-low reset.
- cmp_din  in  DW  signed input sample (the CIC output).
- cmp_din_vld  in  1  one-cycle strobe; cmp_din is valid in this cycle.
- cmp_dout  out  OW  signed filtered, decimated sample.
- cmp_dout_vld  out  1  one-cycle strobe marking a new cmp_dout.
- cmp_busy  out  1  high while a MAC sequence is in progress.
- cmp_ovr  out  1  sticky: a cmp_din_vld arrived while busy; cleared only by reset.

Behaviour:
- Reset (async, cmp_rstn low):
  - Delay line x[0..NTAP-1] = 0, phase = 0, state = IDLE.
  - cmp_dout = 0, cmp_dout_vld = 0, cmp_busy = 0, cmp_ovr = 0.
  - Reset asserted mid-sequence aborts it; no cmp_dout_vld is produced for that sequence.
- Accept (in IDLE only, on cmp_din_vld):
  - Shift the delay line: x[k] <= x[k-1], x[0] <= cmp_din.
  - Toggle phase.
  - If phase was 1 (second sample of the pair), move to MAC next cycle. Otherwise stay in IDLE.
  - The first output after reset uses the 2nd accepted sample.
- State machine IDLE -> MAC -> RND -> OUT -> IDLE:
  - MAC: NTAP/2 cycles. Index k = 0..NTAP/2-1, acc = sum over k of (x[k] + x[NTAP-1-k]) * c[k].
    - Pre-add is DW+1 bits, sign-extended.
    - acc is cleared on the first MAC cycle.
  - RND: r = (acc + 2^(CW-2)) >>> (CW-1), i.e. round half toward +inf, arithmetic shift.
  - OUT: cmp_dout <= r narrowed to OW bits (see optional feature); cmp_dout_vld = 1 for exactly this one cycle.
- Latency: cmp_dout_vld is asserted exactly NTAP/2+3 = 11 cycles after the cmp_din_vld cycle that completed the pair.
- cmp_dout holds its value between strobes.
- cmp_busy = (state != IDLE).
- Minimum input spacing is 12 cycles; the CIC spacing of 32 cycles always satisfies this.
- cmp_din_vld while busy:
  - Sample is dropped; delay line and phase are unchanged.
  - cmp_ovr is set; the in-flight result is unaffected.
- cmp_din_vld in the same cycle as OUT is dropped and flags cmp_ovr (state is not IDLE).
- Coefficients c[0..7] = -6, 10, 25, -38, -85, 110, 400, 608. DC gain is exactly 1.0 (2*sum = 2048).

Optional Feature:
- CMP_SAT_EN defined: r outside [-2^(OW-1), 2^(OW-1)-1] clamps to -32768 / 32767.
- CMP_SAT_EN undefined: cmp_dout = r[OW-1:0] (two's-complement wrap), with no saturation logic.

Decomposition:
- Package cmp_fir_pkg:
  - NTAP, DW, CW, OW, AW defaults.
  - Coefficient constant array c[0..7].
  - State encodings IDLE/MAC/RND/OUT.
  - Rounding constant 2^(CW-2).
- Sub-module cmp_fir_mac:
  - Pre-adder, multiplier and accumulator with clear/enable inputs.
  - Top level keeps the delay line, phase, FSM, tap index counter, rounding and saturation.

Test Plan:
- DC: 40 strobes of cmp_din = 1000 at 32-cycle spacing -> after the delay line fills, every cmp_dout = 1000; cmp_ovr stays 0.
- Impulse: reset, then 1024 followed by zeros, strobes every 32 cycles -> successive outputs 5, -19, 55, 304, 200, -42, 13, -3, then 0.
- Latency: check cmp_dout_vld exactly 11 cycles after each even-numbered strobe and never after odd ones; cmp_busy high for those 11 cycles.
- Overrun: second strobe 4 cycles after a pair-completing strobe -> sample dropped, cmp_ovr = 1 and sticky, current output value unchanged.
- Saturation: load x[k] = +32767 where c[k] > 0 and -32767 where c[k] < 0 (mirrored) -> CMP_SAT_EN gives 32767; without it gives r[15:0] of r = 41023, i.e. -24513.
- Reset mid-MAC: drop cmp_rstn during cycle 3 of MAC -> all outputs 0 immediately, no strobe; after release, phase restarts at 0.

Source files
------------

// File: rtl/cmp_fir_pkg.sv
// ----------------------------------------------------------------------------
// cmp_fir_pkg
// Shared constants and types for the CIC droop-compensation FIR (cic_comp_fir).
//   NTAP/DW/CW/OW/AW : tap count and datapath widths
//   HALF, KW, PW     : derived MAC-loop length, tap-counter width, product width
//   COEF             : symmetric half of the Q1.11 coefficient set, c[0..7]
//   RND_K            : rounding constant 2^(CW-2) (half an output LSB)
//   cmp_state_e      : FSM state encoding
// ----------------------------------------------------------------------------
package cmp_fir_pkg;

    localparam int NTAP = 16;
    localparam int DW   = 16;
    localparam int CW   = 12;
    localparam int OW   = 16;
    localparam int AW   = 32;

    localparam int HALF = NTAP / 2;
    // One extra bit so the counter can reach HALF (the pipeline drain slot).
    localparam int KW   = $clog2(HALF) + 1;
    localparam int PW   = DW + 1 + CW;

    localparam logic signed [AW-1:0] RND_K = AW'(2 ** (CW - 2));

    // Sum of c[0..7] is 1024, so the full 16-tap DC gain is exactly 2048/2048.
    localparam logic signed [CW-1:0] COEF [HALF] = '{
        -12'sd6, 12'sd10, 12'sd25, -12'sd38,
        -12'sd85, 12'sd110, 12'sd400, 12'sd608
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_RND  = 2'd2,
        ST_OUT  = 2'd3
    } cmp_state_e;

endpackage

// File: rtl/cmp_fir_mac.sv
// ----------------------------------------------------------------------------
// cmp_fir_mac
// Time-shared pre-add / multiply / accumulate slice for the symmetric FIR.
// The product is registered before the accumulator, so a result issued in
// cycle n is folded into the accumulator at the end of cycle n+1.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : zero the accumulator this cycle (first MAC issue slot)
//   en_i          : xa_i/xb_i/coef_i hold a valid tap pair this cycle
//   xa_i, xb_i    : mirrored delay-line samples x[k], x[NTAP-1-k] (signed)
//   coef_i        : coefficient c[k] (signed Q1.11)
//   acc_o         : running sum of (x[k]+x[NTAP-1-k])*c[k]
// ----------------------------------------------------------------------------
module cmp_fir_mac
    import cmp_fir_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] xa_i,
    input  logic [DW-1:0] xb_i,
    input  logic [CW-1:0] coef_i,
    output logic [AW-1:0] acc_o
);

    logic signed [DW:0]    pre_add;
    logic signed [PW-1:0]  prod_d;
    logic signed [PW-1:0]  prod_q;
    logic                  prod_vld_q;
    logic signed [AW-1:0]  acc_d;
    logic signed [AW-1:0]  acc_q;

    // Pre-add one bit wider than a sample so x[k] + x[NTAP-1-k] cannot wrap.
    assign pre_add = $signed({xa_i[DW-1], xa_i}) + $signed({xb_i[DW-1], xb_i});
    assign prod_d  = PW'(pre_add) * PW'($signed(coef_i));

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (prod_vld_q) begin
            acc_d = acc_q + AW'(prod_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= en_i;
            acc_q      <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cic_comp_fir.sv
// ----------------------------------------------------------------------------
// cic_comp_fir
// Decimate-by-2, 16-tap symmetric droop-compensation FIR placed after the
// R=32 CIC decimator. Every second accepted sample launches one MAC sequence
// (IDLE -> MAC -> RND -> OUT) that yields one rounded 16-bit output.
//
// Ports
//   cmp_clk        : clock (shared with the CIC)
//   cmp_rstn       : asynchronous active-low reset
//   cmp_din        : signed input sample
//   cmp_din_vld    : one-cycle input strobe
//   cmp_dout       : signed filtered output, held between strobes
//   cmp_dout_vld   : one-cycle strobe marking a new cmp_dout
//   cmp_busy       : a MAC sequence is in flight (state != IDLE)
//   cmp_ovr        : sticky, an input strobe arrived while busy
//   cmp_dbg_state  : current FSM state (cmp_state_e encoding)
//
// Strobe semantics: there is no back-pressure. cmp_din is taken only in a
// cycle where cmp_din_vld is high and cmp_busy is low; a strobe while busy is
// dropped and recorded in cmp_ovr. cmp_dout_vld is a pure one-cycle pulse.
//
// Build option: define CMP_SAT_EN to clamp the rounded result to the output
// range; otherwise the result is wrapped to OW bits.
//
// Timing: a pair-completing strobe in cycle 0 gives MAC in cycles 1..9
// (8 issue slots plus one drain slot for the registered product), RND in
// cycle 10 (cmp_dout loaded) and OUT in cycle 11 (cmp_dout_vld high).
// ----------------------------------------------------------------------------
module cic_comp_fir
    import cmp_fir_pkg::*;
(
    input  logic          cmp_clk,
    input  logic          cmp_rstn,
    input  logic [DW-1:0] cmp_din,
    input  logic          cmp_din_vld,
    output logic [OW-1:0] cmp_dout,
    output logic          cmp_dout_vld,
    output logic          cmp_busy,
    output logic          cmp_ovr,
    output logic [1:0]    cmp_dbg_state
);

    localparam int XIW = $clog2(NTAP);

    cmp_state_e          state_q, state_d;
    logic [KW-1:0]       kidx_q, kidx_d;
    logic                phase_q, phase_d;
    logic                ovr_q, ovr_d;
    logic [OW-1:0]       dout_q, dout_d;
    logic [DW-1:0]       x_q [NTAP];

    logic                accept;
    logic                mac_clr;
    logic                mac_en;
    logic [KW-2:0]       k;
    logic [XIW-1:0]      idx_a;
    logic [XIW-1:0]      idx_b;
    logic [AW-1:0]       acc;
    logic signed [AW-1:0] rnd_sum;
    logic signed [AW-1:0] r_full;
    logic [OW-1:0]       r_nar;

    // ------------------------------------------------------------------
    // Input acceptance, phase and overrun tracking
    // ------------------------------------------------------------------
    assign accept = (state_q == ST_IDLE) && cmp_din_vld;

    always_comb begin
        phase_d = phase_q;
        ovr_d   = ovr_q;
        if (accept) begin
            phase_d = ~phase_q;
        end
        if (cmp_din_vld && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and MAC control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        kidx_d  = kidx_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                kidx_d = '0;
                if (accept && phase_q) begin
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_clr = (kidx_q == '0);
                // Counter values 0..HALF-1 issue a tap pair; HALF drains the product.
                mac_en  = !kidx_q[KW-1];
                if (kidx_q == KW'(HALF)) begin
                    kidx_d  = '0;
                    state_d = ST_RND;
                end else begin
                    kidx_d = kidx_q + 1'b1;
                end
            end
            ST_RND:  state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Tap selection and MAC datapath
    // ------------------------------------------------------------------
    assign k     = kidx_q[KW-2:0];
    assign idx_a = {1'b0, k};
    assign idx_b = XIW'(NTAP - 1) - {1'b0, k};

    cmp_fir_mac u_mac (
        .clk_i  (cmp_clk),
        .rst_ni (cmp_rstn),
        .clr_i  (mac_clr),
        .en_i   (mac_en),
        .xa_i   (x_q[idx_a]),
        .xb_i   (x_q[idx_b]),
        .coef_i (COEF[k]),
        .acc_o  (acc)
    );

    // ------------------------------------------------------------------
    // Round half toward +inf, then narrow to the output width
    // ------------------------------------------------------------------
    assign rnd_sum = $signed(acc) + RND_K;
    assign r_full  = rnd_sum >>> (CW - 1);

`ifdef CMP_SAT_EN
    localparam logic signed [AW-1:0] OUT_MAX = AW'(2 ** (OW - 1) - 1);
    localparam logic signed [AW-1:0] OUT_MIN = -AW'(2 ** (OW - 1));

    always_comb begin
        r_nar = r_full[OW-1:0];
        if (r_full > OUT_MAX) begin
            r_nar = {1'b0, {(OW-1){1'b1}}};
        end else if (r_full < OUT_MIN) begin
            r_nar = {1'b1, {(OW-1){1'b0}}};
        end
    end
`else
    logic unused_r_hi;

    assign r_nar       = r_full[OW-1:0];
    assign unused_r_hi = ^r_full[AW-1:OW];
`endif

    always_comb begin
        dout_d = dout_q;
        if (state_q == ST_RND) begin
            dout_d = r_nar;
        end
    end

    // ------------------------------------------------------------------
    // State registers and delay line
    // ------------------------------------------------------------------
    always_ff @(posedge cmp_clk or negedge cmp_rstn) begin
        if (!cmp_rstn) begin
            state_q <= ST_IDLE;
            kidx_q  <= '0;
            phase_q <= 1'b0;
            ovr_q   <= 1'b0;
            dout_q  <= '0;
            for (int i = 0; i < NTAP; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            kidx_q  <= kidx_d;
            phase_q <= phase_d;
            ovr_q   <= ovr_d;
            dout_q  <= dout_d;
            if (accept) begin
                for (int i = NTAP - 1; i > 0; i--) begin
                    x_q[i] <= x_q[i-1];
                end
                x_q[0] <= cmp_din;
            end
        end
    end

    assign cmp_dout      = dout_q;
    assign cmp_dout_vld  = (state_q == ST_OUT);
    assign cmp_busy      = (state_q != ST_IDLE);
    assign cmp_ovr       = ovr_q;
    assign cmp_dbg_state = state_q;

endmodule
